// File: rtl/exception_ctrl.sv
// Precise-exception controller: fixed-priority arbitration of exception sources,
// EPC/Cause/BadVAddr capture, timed pipeline flush, fetch redirect, ERET and fatal halt.
module exception_ctrl #(
  parameter int unsigned                  NUM_SRC    = 9,
  parameter int unsigned                  CODE_W     = 5,
  parameter logic [NUM_SRC*CODE_W-1:0]    CODES      = {5'd9, 5'd12, 5'd10, 5'd11, 5'd7,
                                                        5'd6, 5'd5, 5'd4, 5'd4},
  parameter logic [NUM_SRC-1:0]           FATAL_MASK = 9'b000001001,
  parameter logic [NUM_SRC-1:0]           BVA_MASK   = 9'b000011111,
  parameter logic [NUM_SRC-1:0]           DSEL_MASK  = 9'b000010110,
  parameter int unsigned                  FLUSH_CYC  = 2,
  parameter logic [31:0]                  VECTOR     = 32'h8000_0180,
  parameter int unsigned                  CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [NUM_SRC-1:0]  ex_req,
  input  logic [31:0]         pc,
  input  logic [31:0]         data_addr,
  input  logic                eret,
  output logic                exc_taken,
  output logic                flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         epc,
  output logic [CODE_W-1:0]   cause,
  output logic [31:0]         bva,
  output logic                exl,
  output logic                halt,
  output logic [CNT_W-1:0]    exc_count
);

  localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              exc_taken_q, exc_taken_d;
  logic              flush_q, flush_d;
  logic              rv_q, rv_d;
  logic [31:0]       rpc_q, rpc_d;
  logic [31:0]       epc_q, epc_d;
  logic [CODE_W-1:0] cause_q, cause_d;
  logic [31:0]       bva_q, bva_d;
  logic              exl_q, exl_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CODE_W-1:0] win_code;
  logic              win_fatal, win_bva, win_dsel;

  // Scan from lowest priority upward so the lowest set index is the last write.
  always_comb begin
    win_code  = '0;
    win_fatal = 1'b0;
    win_bva   = 1'b0;
    win_dsel  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (ex_req[i]) begin
        win_code  = CODES[i*CODE_W +: CODE_W];
        win_fatal = FATAL_MASK[i];
        win_bva   = BVA_MASK[i];
        win_dsel  = DSEL_MASK[i];
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    exc_taken_d = 1'b0;
    flush_d     = flush_q;
    rv_d        = 1'b0;
    rpc_d       = rpc_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    bva_d       = bva_q;
    exl_d       = exl_q;
    halt_d      = halt_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|ex_req) begin
          exc_taken_d = 1'b1;
          cause_d     = win_code;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!exl_q) epc_d = pc;
          exl_d       = 1'b1;
          if (win_bva) bva_d = win_dsel ? data_addr : pc;
          flush_d     = 1'b1;
          if (win_fatal) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYC - 1);
          end
        end else if (eret && exl_q) begin
          exl_d = 1'b0;
          rpc_d = epc_q;
          rv_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_REDIR;
          flush_d = 1'b0;
          rv_d    = 1'b1;
          rpc_d   = VECTOR;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      S_REDIR: state_d = S_IDLE;
      S_HALT: begin
        flush_d = 1'b1;
        halt_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      exc_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      rv_q        <= 1'b0;
      rpc_q       <= '0;
      epc_q       <= '0;
      cause_q     <= '0;
      bva_q       <= '0;
      exl_q       <= 1'b0;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      exc_taken_q <= exc_taken_d;
      flush_q     <= flush_d;
      rv_q        <= rv_d;
      rpc_q       <= rpc_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      bva_q       <= bva_d;
      exl_q       <= exl_d;
      halt_q      <= halt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign exc_taken      = exc_taken_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign bva            = bva_q;
  assign exl            = exl_q;
  assign halt           = halt_q;
  assign exc_count      = cnt_q;

endmodule
